// File: rtl/axi_burst_mem_responder.sv
// ---------------------------------------------------------------------------
// AxiBurstMemResponder (module axi_burst_mem_responder)
//
// AXI4 slave that backs a word-addressed on-chip RAM and serves one burst at
// a time: a write burst (AW -> W -> B) or a read burst (AR -> R). Only 32-bit
// INCR bursts are honoured; anything else completes its beat count but with
// SLVERR and no RAM side effects.
//
// Ports:
//   clk, rst_n         rising-edge clock, asynchronous active-low reset
//   aw*                write address channel (id, addr, len, size, burst)
//   w*                 write data channel (32-bit data, 4-bit strobe, last)
//   b*                 write response channel
//   ar*                read address channel (id, addr, len, size, burst)
//   r*                 read data channel (32-bit data, resp, last)
//   busy               high whenever a transaction is in progress
// ---------------------------------------------------------------------------
module axi_burst_mem_responder #(
  parameter int unsigned MEM_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned ID_WIDTH  = 4
) (
  input  logic                clk,
  input  logic                rst_n,

  input  logic [ID_WIDTH-1:0] awid,
  input  logic [31:0]         awaddr,
  input  logic [7:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic                awvalid,
  output logic                awready,

  input  logic [31:0]         wdata,
  input  logic [3:0]          wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,

  output logic [ID_WIDTH-1:0] bid,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,

  input  logic [ID_WIDTH-1:0] arid,
  input  logic [31:0]         araddr,
  input  logic [7:0]          arlen,
  input  logic [2:0]          arsize,
  input  logic [1:0]          arburst,
  input  logic                arvalid,
  output logic                arready,

  output logic [ID_WIDTH-1:0] rid,
  output logic [31:0]         rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready,

  output logic                busy
);

  localparam int unsigned IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  // Byte span of the RAM, one bit wider so a full 4 GiB window still fits.
  localparam logic [32:0] SPAN  = 33'(MEM_WORDS) * 33'd4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    W_DATA,
    W_RESP,
    R_DATA
  } state_t;

  state_t state, state_nxt;

  logic [31:0]         mem [MEM_WORDS];

  logic [ID_WIDTH-1:0] id_q;
  logic [31:0]         addr_q;
  logic [7:0]          len_q;
  logic [7:0]          cnt_q;
  logic                fmt_ok_q;
  logic                wrap_q;
  logic                past_end_q;
  logic                err_q;

  logic [31:0]         rdata_q;
  logic [1:0]          rresp_q;
  logic                rlast_q;

  logic                aw_fire, ar_fire, w_fire, r_fire;
  logic [31:0]         addr_nxt;
  logic                addr_carry;
  logic                w_beat_ok;
  logic [IDX_W-1:0]    w_idx;

  logic                rd_load;
  logic [31:0]         rd_addr;
  logic                rd_wrap;
  logic                rd_fmt;
  logic                rd_last;
  logic                rd_ok;
  logic [IDX_W-1:0]    rd_idx;

  // A beat hits RAM only for a 32-bit INCR burst whose address has not
  // wrapped past 2^32 and lies inside the RAM window. Subtracting BASE_ADDR
  // first makes addresses below the base wrap to huge offsets, so a single
  // unsigned compare covers both ends of the window.
  function automatic logic beat_legal(input logic [31:0] addr,
                                      input logic        wrapped,
                                      input logic        fmt_ok);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    return fmt_ok && !wrapped && ({1'b0, off} < SPAN);
  endfunction

  // Low two address bits are dropped; the RAM is word addressed.
  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    return IDX_W'(off >> 2);
  endfunction

  assign aw_fire = awvalid && awready;
  assign ar_fire = arvalid && arready;
  assign w_fire  = wvalid && wready;
  assign r_fire  = rvalid && rready;

  // The carry out of the +4 marks the burst as wrapped; it stays wrapped so
  // every later beat of the same burst is rejected as well.
  assign {addr_carry, addr_nxt} = {1'b0, addr_q} + 33'd4;

  // Beats beyond awlen+1 are dropped even if they would be in range.
  assign w_beat_ok = beat_legal(addr_q, wrap_q, fmt_ok_q) && !past_end_q;
  assign w_idx     = word_idx(addr_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The ready signals are gated by rst_n so the handshake outputs are low for
  // the whole reset period even though the state already reads IDLE. AR is
  // refused whenever AW is pending so writes always win a same-cycle race.
  always_comb begin
    state_nxt = state;
    awready   = 1'b0;
    arready   = 1'b0;
    wready    = 1'b0;
    bvalid    = 1'b0;
    rvalid    = 1'b0;
    busy      = 1'b1;

    case (state)
      IDLE: begin
        busy    = 1'b0;
        awready = rst_n;
        arready = rst_n && !awvalid;
        if (aw_fire) begin
          state_nxt = W_DATA;
        end else if (ar_fire) begin
          state_nxt = R_DATA;
        end
      end
      W_DATA: begin
        wready = 1'b1;
        if (w_fire && wlast) begin
          state_nxt = W_RESP;
        end
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) begin
          state_nxt = IDLE;
        end
      end
      R_DATA: begin
        rvalid = 1'b1;
        if (r_fire && rlast_q) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Transaction context shared by both directions; only one burst is ever
  // in flight so a single set of address/length/counter registers suffices.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      fmt_ok_q   <= 1'b0;
      wrap_q     <= 1'b0;
      past_end_q <= 1'b0;
      err_q      <= 1'b0;
    end else if (aw_fire) begin
      id_q       <= awid;
      addr_q     <= awaddr;
      len_q      <= awlen;
      cnt_q      <= '0;
      fmt_ok_q   <= (awsize == 3'b010) && (awburst == 2'b01);
      wrap_q     <= 1'b0;
      past_end_q <= 1'b0;
      err_q      <= 1'b0;
    end else if (ar_fire) begin
      id_q       <= arid;
      addr_q     <= araddr;
      len_q      <= arlen;
      cnt_q      <= '0;
      fmt_ok_q   <= (arsize == 3'b010) && (arburst == 2'b01);
      wrap_q     <= 1'b0;
      past_end_q <= 1'b0;
    end else if (w_fire) begin
      addr_q <= addr_nxt;
      wrap_q <= wrap_q | addr_carry;
      cnt_q  <= cnt_q + 8'd1;
      // past_end_q guards against the 8-bit counter wrapping back onto
      // awlen during an overlong burst.
      if (cnt_q == len_q) begin
        past_end_q <= 1'b1;
      end
      if (!w_beat_ok || (wlast && (past_end_q || (cnt_q != len_q)))) begin
        err_q <= 1'b1;
      end
    end else if (r_fire) begin
      addr_q <= addr_nxt;
      wrap_q <= wrap_q | addr_carry;
      cnt_q  <= cnt_q + 8'd1;
    end
  end

  // RAM write port, byte-lane masked. The RAM itself is never reset.
  always_ff @(posedge clk) begin
    if (w_fire && w_beat_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) begin
          mem[w_idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  // Read data is prefetched into an output register: the first beat is
  // fetched on the AR handshake, each following beat on the handshake of the
  // previous one. This gives the one-cycle AR->R latency, lets beats stream
  // back to back, and keeps rdata/rresp/rlast frozen while rready is low.
  always_comb begin
    rd_load = 1'b0;
    rd_addr = addr_nxt;
    rd_wrap = wrap_q | addr_carry;
    rd_fmt  = fmt_ok_q;
    rd_last = 1'b0;
    if (ar_fire) begin
      rd_load = 1'b1;
      rd_addr = araddr;
      rd_wrap = 1'b0;
      rd_fmt  = (arsize == 3'b010) && (arburst == 2'b01);
      rd_last = (arlen == 8'd0);
    end else if (r_fire && !rlast_q) begin
      rd_load = 1'b1;
      rd_last = ((cnt_q + 8'd1) == len_q);
    end
  end

  assign rd_ok  = beat_legal(rd_addr, rd_wrap, rd_fmt);
  assign rd_idx = word_idx(rd_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
      rlast_q <= 1'b0;
    end else if (rd_load) begin
      rdata_q <= rd_ok ? mem[rd_idx] : 32'd0;
      rresp_q <= rd_ok ? RESP_OKAY : RESP_SLVERR;
      rlast_q <= rd_last;
    end
  end

  assign bid   = id_q;
  assign bresp = err_q ? RESP_SLVERR : RESP_OKAY;
  assign rid   = id_q;
  assign rdata = rdata_q;
  assign rresp = rresp_q;
  assign rlast = rvalid && rlast_q;

endmodule

// File: tb/tb_axi_burst_mem_responder.sv
// ---------------------------------------------------------------------------
// Testbench for axi_burst_mem_responder. Directed bursts exercise the main
// scenarios (long INCR bursts, AW/AR priority, read back-pressure, strobes,
// out-of-range and bad-format bursts, wrap, reset mid-burst) and a random
// phase mixes reads and writes. Expected values come from a word-array model
// of the RAM and plain arithmetic on burst addresses.
// ---------------------------------------------------------------------------
module tb_axi_burst_mem_responder;

  localparam int          MEM_WORDS = 4096;
  localparam logic [31:0] BASE_ADDR = 32'h0000_0000;
  localparam int          ID_WIDTH  = 4;
  localparam logic [63:0] MEM_END   = {32'd0, BASE_ADDR} + 64'(MEM_WORDS) * 64'd4;

  logic                clk;
  logic                rst_n;
  logic [ID_WIDTH-1:0] awid;
  logic [31:0]         awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;
  logic [31:0]         wdata;
  logic [3:0]          wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [ID_WIDTH-1:0] bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ID_WIDTH-1:0] arid;
  logic [31:0]         araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;
  logic [ID_WIDTH-1:0] rid;
  logic [31:0]         rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;
  logic                busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem   [MEM_WORDS];
  bit          model_known [MEM_WORDS];
  logic [31:0] wq_data [$];
  logic [3:0]  wq_strb [$];

  axi_burst_mem_responder #(
    .MEM_WORDS (MEM_WORDS),
    .BASE_ADDR (BASE_ADDR),
    .ID_WIDTH  (ID_WIDTH)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .awid    (awid),
    .awaddr  (awaddr),
    .awlen   (awlen),
    .awsize  (awsize),
    .awburst (awburst),
    .awvalid (awvalid),
    .awready (awready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wlast   (wlast),
    .wvalid  (wvalid),
    .wready  (wready),
    .bid     (bid),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready),
    .arid    (arid),
    .araddr  (araddr),
    .arlen   (arlen),
    .arsize  (arsize),
    .arburst (arburst),
    .arvalid (arvalid),
    .arready (arready),
    .rid     (rid),
    .rdata   (rdata),
    .rresp   (rresp),
    .rlast   (rlast),
    .rvalid  (rvalid),
    .rready  (rready),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Beat legality from first principles: full-width address arithmetic, so
  // a burst running past 2^32 is visible as a value above 32 bits.
  function automatic bit exp_legal(input logic [31:0] start, input int beat,
                                   input logic [2:0] size, input logic [1:0] burst);
    logic [63:0] a;
    a = {32'd0, start} + 64'(beat) * 64'd4;
    if (size != 3'b010 || burst != 2'b01) return 1'b0;
    if (a > 64'h0000_0000_FFFF_FFFF) return 1'b0;
    return (a >= {32'd0, BASE_ADDR}) && (a < MEM_END);
  endfunction

  function automatic int exp_index(input logic [31:0] start, input int beat);
    logic [63:0] a;
    a = {32'd0, start} + 64'(beat) * 64'd4 - {32'd0, BASE_ADDR};
    return int'(a >> 2);
  endfunction

  task automatic issue_aw(input logic [3:0] id, input logic [31:0] addr,
                          input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, output bit ok);
    int t;
    t = 0;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
    awvalid = 1'b1;
    #1;
    while (!awready && t < 200) begin
      @(negedge clk);
      t++;
    end
    ok = awready;
    if (!ok) begin
      checkOutput("aw_timeout", 64'(awready), 64'(1));
      awvalid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    awvalid = 1'b0;
  endtask

  task automatic issue_ar(input logic [3:0] id, input logic [31:0] addr,
                          input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, output bit ok);
    int t;
    t = 0;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
    arvalid = 1'b1;
    #1;
    while (!arready && t < 200) begin
      @(negedge clk);
      t++;
    end
    ok = arready;
    if (!ok) begin
      checkOutput("ar_timeout", 64'(arready), 64'(1));
      arvalid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0;
  endtask

  // Sends the queued W beats (wlast on the final one), updates the model and
  // collects the B response.
  task automatic send_w(input logic [3:0] id, input logic [31:0] addr,
                        input logic [7:0] len, input logic [2:0] size,
                        input logic [1:0] burst, input bit check_ar_blocked);
    int n;
    int t;
    int idx;
    bit exp_err;
    n = wq_data.size();
    exp_err = (n != int'(len) + 1);
    for (int i = 0; i < n; i++) begin
      if (i > int'(len)) begin
        exp_err = 1'b1;
      end else if (!exp_legal(addr, i, size, burst)) begin
        exp_err = 1'b1;
      end else begin
        idx = exp_index(addr, i);
        for (int b = 0; b < 4; b++) begin
          if (wq_strb[i][b]) model_mem[idx][8*b +: 8] = wq_data[i][8*b +: 8];
        end
        model_known[idx] = model_known[idx] || (wq_strb[i] == 4'hF);
      end
    end

    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        wvalid = 1'b0;
        @(negedge clk);
        if (check_ar_blocked) checkOutput("ar_blocked_w", 64'(arready), 64'(0));
      end
      wvalid = 1'b1;
      wdata  = wq_data[i];
      wstrb  = wq_strb[i];
      wlast  = (i == n - 1);
      t = 0;
      while (!wready && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (!wready) begin
        checkOutput("w_timeout", 64'(wready), 64'(1));
        wvalid = 1'b0;
        wq_data.delete();
        wq_strb.delete();
        return;
      end
      if (check_ar_blocked) checkOutput("ar_blocked_w", 64'(arready), 64'(0));
      @(posedge clk);
      @(negedge clk);
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    wq_data.delete();
    wq_strb.delete();

    t = 0;
    while (!bvalid && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bvalid) begin
      checkOutput("b_timeout", 64'(bvalid), 64'(1));
      return;
    end
    repeat ($urandom_range(0, 2)) @(negedge clk);
    checkOutput("b_held", 64'(bvalid), 64'(1));
    checkOutput("bresp", 64'(bresp), exp_err ? 64'(2) : 64'(0));
    checkOutput("bid", 64'(bid), 64'(id));
    if (check_ar_blocked) checkOutput("ar_blocked_b", 64'(arready), 64'(0));
    bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bready = 1'b0;
  endtask

  // Collects an R burst. mode 0: rready always high, 1: pattern 1,0,0,...,
  // 2: random. abort_at >= 0 pulls reset when that beat is presented.
  task automatic collect_r(input logic [3:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input int mode,
                           input int abort_at);
    int i;
    int cyc;
    int idx;
    bit stall;
    bit legal;
    logic [31:0] s_data;
    logic [1:0]  s_resp;
    logic        s_last;
    i = 0; cyc = 0; stall = 1'b0;
    s_data = '0; s_resp = '0; s_last = 1'b0;
    checkOutput("r_latency", 64'(rvalid), 64'(1));
    while (i <= int'(len) && cyc < 5000) begin
      if (stall) begin
        checkOutput("r_stall_valid", 64'(rvalid), 64'(1));
        checkOutput("r_stall_data", 64'(rdata), 64'(s_data));
        checkOutput("r_stall_resp", 64'(rresp), 64'(s_resp));
        checkOutput("r_stall_last", 64'(rlast), 64'(s_last));
      end
      case (mode)
        0:       rready = 1'b1;
        1:       rready = (cyc % 3 == 0);
        default: rready = 1'($urandom_range(0, 1));
      endcase
      if (mode == 0) checkOutput("r_no_bubble", 64'(rvalid), 64'(1));
      if (rvalid && i == abort_at) begin
        rst_n  = 1'b0;
        rready = 1'b0;
        #1;
        checkOutput("rst_rvalid", 64'(rvalid), 64'(0));
        checkOutput("rst_busy", 64'(busy), 64'(0));
        checkOutput("rst_rlast", 64'(rlast), 64'(0));
        checkOutput("rst_awready", 64'(awready), 64'(0));
        checkOutput("rst_arready", 64'(arready), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("post_rst_awready", 64'(awready), 64'(1));
        return;
      end
      if (rvalid && rready) begin
        legal = exp_legal(addr, i, size, burst);
        checkOutput("rid", 64'(rid), 64'(id));
        checkOutput("rlast", 64'(rlast), 64'(i == int'(len)));
        checkOutput("rresp", 64'(rresp), legal ? 64'(0) : 64'(2));
        if (!legal) begin
          checkOutput("rdata_err", 64'(rdata), 64'(0));
        end else begin
          idx = exp_index(addr, i);
          if (model_known[idx]) checkOutput("rdata", 64'(rdata), 64'(model_mem[idx]));
        end
        i++;
      end
      stall  = rvalid && !rready;
      s_data = rdata;
      s_resp = rresp;
      s_last = rlast;
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    rready = 1'b0;
    checkOutput("r_beats", 64'(i), 64'(len) + 64'd1);
    checkOutput("busy_after_read", 64'(busy), 64'(0));
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr,
                          input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst);
    bit ok;
    issue_aw(id, addr, len, size, burst, ok);
    if (ok) begin
      send_w(id, addr, len, size, burst, 1'b0);
    end else begin
      wq_data.delete();
      wq_strb.delete();
    end
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input int mode, input int abort_at);
    bit ok;
    issue_ar(id, addr, len, size, burst, ok);
    if (ok) collect_r(id, addr, len, size, burst, mode, abort_at);
  endtask

  // Random mix of reads and writes, mostly legal, some near the top of the
  // RAM and some with an unsupported size or burst type.
  task automatic applyStimulus(input int n);
    for (int k = 0; k < n; k++) begin
      logic [31:0] a;
      logic [7:0]  l;
      logic [2:0]  sz;
      logic [1:0]  bu;
      logic [3:0]  id;
      l  = 8'($urandom_range(0, 15));
      id = 4'($urandom_range(0, 15));
      sz = ($urandom_range(0, 7) == 0) ? 3'b001 : 3'b010;
      bu = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b01;
      if ($urandom_range(0, 7) == 0)
        a = 32'(MEM_END - 64'd4 * 64'($urandom_range(0, 8)));
      else
        a = BASE_ADDR + 32'($urandom_range(0, MEM_WORDS - 1)) * 32'd4;
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i <= int'(l); i++) begin
          wq_data.push_back($urandom);
          wq_strb.push_back(4'($urandom_range(1, 15)));
        end
        do_write(id, a, l, sz, bu);
      end else begin
        do_read(id, a, l, sz, bu, 2, -1);
      end
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit ok;
    rst_n = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    rready = 1'b0;
    for (int i = 0; i < MEM_WORDS; i++) begin
      model_mem[i]   = '0;
      model_known[i] = 1'b0;
    end

    repeat (3) @(negedge clk);
    checkOutput("reset_awready", 64'(awready), 64'(0));
    checkOutput("reset_arready", 64'(arready), 64'(0));
    checkOutput("reset_wready", 64'(wready), 64'(0));
    checkOutput("reset_bvalid", 64'(bvalid), 64'(0));
    checkOutput("reset_rvalid", 64'(rvalid), 64'(0));
    checkOutput("reset_rlast", 64'(rlast), 64'(0));
    checkOutput("reset_bresp", 64'(bresp), 64'(0));
    checkOutput("reset_rresp", 64'(rresp), 64'(0));
    checkOutput("reset_bid", 64'(bid), 64'(0));
    checkOutput("reset_rid", 64'(rid), 64'(0));
    checkOutput("reset_rdata", 64'(rdata), 64'(0));
    checkOutput("reset_busy", 64'(busy), 64'(0));
    rst_n = 1'b1;
    #1;
    checkOutput("idle_awready", 64'(awready), 64'(1));
    checkOutput("idle_arready", 64'(arready), 64'(1));
    @(negedge clk);

    $display("[TB] 128-beat write and read back at 0x0");
    for (int i = 0; i < 128; i++) begin
      wq_data.push_back(32'(i));
      wq_strb.push_back(4'hF);
    end
    do_write(4'h3, 32'h0, 8'd127, 3'b010, 2'b01);
    do_read(4'h3, 32'h0, 8'd127, 3'b010, 2'b01, 0, -1);

    $display("[TB] simultaneous AW and AR");
    wq_data.push_back(32'hCAFE_0001); wq_strb.push_back(4'hF);
    wq_data.push_back(32'hCAFE_0002); wq_strb.push_back(4'hF);
    awid = 4'h5; awaddr = 32'h200; awlen = 8'd1; awsize = 3'b010; awburst = 2'b01;
    arid = 4'h6; araddr = 32'h0;   arlen = 8'd3; arsize = 3'b010; arburst = 2'b01;
    awvalid = 1'b1;
    arvalid = 1'b1;
    #1;
    checkOutput("prio_awready", 64'(awready), 64'(1));
    checkOutput("prio_arready", 64'(arready), 64'(0));
    @(posedge clk);
    @(negedge clk);
    awvalid = 1'b0;
    send_w(4'h5, 32'h200, 8'd1, 3'b010, 2'b01, 1'b1);
    checkOutput("ar_after_b", 64'(arready), 64'(1));
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0;
    collect_r(4'h6, 32'h0, 8'd3, 3'b010, 2'b01, 0, -1);
    do_read(4'h5, 32'h200, 8'd1, 3'b010, 2'b01, 2, -1);

    $display("[TB] read with rready pattern 1,0,0");
    do_read(4'h3, 32'h0, 8'd127, 3'b010, 2'b01, 1, -1);

    $display("[TB] byte strobes");
    wq_data.push_back(32'hAABB_CCDD); wq_strb.push_back(4'hF);
    do_write(4'h1, 32'h10, 8'd0, 3'b010, 2'b01);
    wq_data.push_back(32'h1122_3344); wq_strb.push_back(4'b0101);
    do_write(4'h1, 32'h10, 8'd0, 3'b010, 2'b01);
    do_read(4'h2, 32'h10, 8'd0, 3'b010, 2'b01, 0, -1);

    $display("[TB] top-of-memory and bad-format bursts");
    wq_data.push_back(32'h5555_AAAA); wq_strb.push_back(4'hF);
    wq_data.push_back(32'h0F0F_F0F0); wq_strb.push_back(4'hF);
    do_write(4'h7, 32'(MEM_END - 64'd8), 8'd1, 3'b010, 2'b01);
    do_read(4'h7, 32'(MEM_END - 64'd8), 8'd3, 3'b010, 2'b01, 2, -1);
    wq_data.push_back(32'hDEAD_BEEF); wq_strb.push_back(4'hF);
    do_write(4'h8, 32'h20, 8'd0, 3'b001, 2'b01);
    do_read(4'h8, 32'h20, 8'd0, 3'b010, 2'b01, 0, -1);
    do_read(4'h9, 32'h40, 8'd2, 3'b010, 2'b10, 0, -1);
    do_read(4'hA, 32'hFFFF_FFF8, 8'd3, 3'b010, 2'b01, 0, -1);

    $display("[TB] short and overlong write bursts");
    wq_data.push_back(32'h1111_0000); wq_strb.push_back(4'hF);
    wq_data.push_back(32'h1111_0001); wq_strb.push_back(4'hF);
    do_write(4'hB, 32'h300, 8'd3, 3'b010, 2'b01);
    for (int i = 0; i < 3; i++) begin
      wq_data.push_back(32'h2222_0000 + 32'(i));
      wq_strb.push_back(4'hF);
    end
    do_write(4'hC, 32'h400, 8'd1, 3'b010, 2'b01);
    do_read(4'hC, 32'h400, 8'd2, 3'b010, 2'b01, 0, -1);

    $display("[TB] random traffic");
    applyStimulus(24);

    $display("[TB] reset during read");
    do_read(4'h3, 32'h0, 8'd127, 3'b010, 2'b01, 0, 50);
    issue_ar(4'h4, 32'h0, 8'd127, 3'b010, 2'b01, ok);
    if (ok) collect_r(4'h4, 32'h0, 8'd127, 3'b010, 2'b01, 2, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_burst_mem_responder.md
Name: axi_burst_mem_responder

Overview:
- AXI4 slave (responder) that terminates the burst traffic produced by the cache-side request arbiter.
- Backs an on-chip word-addressed RAM and is used as the simulation and FPGA main memory behind the core's single external AXI master port.
- Serves one transaction at a time: either a write burst (AW→W→B) or a read burst (AR→R).
- Supports the INCR 32-bit bursts issued by I$/D$ refills and write-backs; the default length is 128 beats.

Parameters:
- MEM_WORDS, 4096, RAM depth in 32-bit words.
- BASE_ADDR, 32'h0000_0000, byte address of word 0.
- ID_WIDTH, 4, width of the AXI ID fields (awid/arid/bid/rid).

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- s_axi  axi_if.slave  -  AXI4 slave port. Data 32 bits, address 32 bits, strobe 4 bits, IDs ID_WIDTH bits. All five channels are used.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, W_DATA, W_RESP, R_DATA.
- Reset:
  - state=IDLE; awready=wready=arready=0 while rst_n=0.
  - bvalid=rvalid=rlast=0; bresp=rresp=0; bid=rid=0; rdata=0; busy=0.
  - RAM contents are not reset.
- IDLE:
  - awready=1.
  - arready=1 only when awvalid=0. Writes have priority; if awvalid and arvalid are both high, only AW handshakes.
  - On AW handshake, latch awid, awaddr, awlen, awsize, awburst and clear the error flag. Go to W_DATA.
  - On AR handshake, latch arid, araddr, arlen, arsize, arburst. Go to R_DATA; rvalid rises the next cycle (1-cycle latency).
- W_DATA:
  - wready=1.
  - Each W handshake writes the byte lanes selected by wstrb into RAM[cur_word], but only if the beat is legal (see Error rules).
  - Address advances +4 per beat (INCR).
  - The beat counter is 8 bits and is compared against awlen.
  - Beats after the (awlen+1)th are dropped and set err.
  - The W handshake with wlast=1 ends the phase and goes to W_RESP. If the counter≠awlen at that beat, set err.
- W_RESP:
  - bvalid=1, bid=latched id, bresp = err ? 2'b10 (SLVERR) : 2'b00.
  - bvalid is held until bready.
  - On the handshake, go to IDLE; awready/arready rise the following cycle.
- R_DATA:
  - rvalid=1, rid=latched id.
  - rdata = RAM[cur_word] for a legal beat, otherwise 0 with rresp=SLVERR; per-beat rresp otherwise OKAY.
  - rlast=1 exactly when counter==arlen.
  - rdata, rresp and rlast stay stable while rvalid=1 and rready=0.
  - Each handshake advances address and counter. Beats are back-to-back with no bubbles while rready stays high.
  - The handshake with rlast=1 goes to IDLE.
- Error rules:
  - A beat is illegal if its address is outside [BASE_ADDR, BASE_ADDR+4*MEM_WORDS).
  - All beats are illegal if size≠3'b010 or burst≠2'b01 (INCR).
  - An illegal write beat performs no RAM write and sets err.
  - The burst still completes its full beat count.
- Address arithmetic:
  - word index = (addr − BASE_ADDR) >> 2.
  - Low address bits [1:0] are ignored.
  - The 32-bit address wraps modulo 2^32; the wrapped beat is then out of range and therefore SLVERR.
- Reset asserted mid-transaction: all outputs go to reset values immediately (asynchronous). The partial burst is abandoned; already-written beats remain in RAM.
- The block never accepts AW and AR in the same cycle, and never accepts a new request before the current one's B or last R handshake.

Test Plan:
- Write burst at 0x0, awlen=127, wdata=beat index, wlast on beat 127; then read burst at 0x0, arlen=127 → bresp=00; rdata[i]=i; rlast only on beat 127; rresp=00; rid=arid=4'h3.
- Hold awvalid and arvalid high together in IDLE → AW accepted; arready=0 until the B handshake; AR is accepted in the cycle after IDLE is re-entered.
- Read with rready toggled 1,0,0,1,… → no beat lost or duplicated; rdata/rlast stable during stalls; 128 handshakes total.
- RAM[4]=32'hAABBCCDD; write single beat at 0x10, wdata=32'h11223344, wstrb=4'b0101 → read back 32'hAA22CC44.
- Read at BASE_ADDR+4*MEM_WORDS−8, arlen=3 → beats 0–1 OKAY with RAM data; beats 2–3 rresp=10 with rdata=0. Write with awsize=3'b001 → bresp=10 and RAM unchanged.
- Pull rst_n low at read beat 50 → rvalid=0 and busy=0 immediately. After release, awready=1 and a new read returns the previously written data.
